frame_mem_arbiter: RTL and testbench
====================================

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 96, memory word width (4 pixels x 24 bit).
- ADDR_DEPTH, 512*512/4, words per frame.
- ADDR_WIDTH, $clog2(ADDR_DEPTH), address width.
- STARVE_LIMIT, 8, write wait cycles before forced write grant (range 1..255).
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- i_ren, in, 1, read request from the display read controller.
- i_raddr, in, ADDR_WIDTH, read address.
- o_rgnt, out, 1, read accepted this cycle.
- o_rvalid, out, 1, o_rdata valid.
- o_rdata, out, DATA_WIDTH, read data.
- i_wvalid, in, 1, write request from the input write controller.
- i_waddr, in, ADDR_WIDTH, write address.
- i_wdata, in, DATA_WIDTH, write data.
- o_wready, out, 1, write accepted this cycle.
- o_mem_cs, out, 1, single-port SRAM chip select.
- o_mem_we, out, 1, SRAM write enable.
- o_mem_addr, out, ADDR_WIDTH, SRAM address.
- o_mem_wdata, out, DATA_WIDTH, SRAM write data.
- i_mem_rdata, in, DATA_WIDTH, SRAM read data, valid one cycle after cs with we=0.

Function
REQ-003 The block SHALL share one single-port SRAM between one read and one write requester, at most one access per cycle.
REQ-004 o_rgnt and o_wready SHALL be combinational from current requests and registered state; never both 1 in the same cycle.
REQ-005 Default priority SHALL be read: i_ren=1 gives o_rgnt=1 and o_wready=0.
REQ-006 i_wvalid=1 with i_ren=0 SHALL give o_wready=1.
REQ-007 A requester SHALL hold request, address and data stable until granted; the block SHALL not latch ungranted requests.
REQ-008 An accepted access in cycle N SHALL drive o_mem_cs=1, o_mem_we, o_mem_addr, o_mem_wdata from registers in cycle N+1; cs=0, we=0 in cycles with no accept.
REQ-009 An accepted read in cycle N SHALL give o_rvalid=1 in cycle N+2, with o_rdata = i_mem_rdata in that cycle (o_rdata is a pass-through); accepted back-to-back reads SHALL give back-to-back o_rvalid.
REQ-010 The FSM SHALL hold registered state S_IDLE (no access in N+1), S_RD (read issued), or S_WR (write issued), updated every cycle from the grant; it SHALL select o_mem_we.
REQ-011 Wait counter wcnt (8 bit) SHALL increment, saturating at STARVE_LIMIT, each cycle with i_wvalid=1 and o_wready=0; it SHALL clear on write accept or when i_wvalid=0.
REQ-012 A read to the address of a write accepted one cycle earlier SHALL return the new data (SRAM write-first; no bypass in this block).

Reset
REQ-013 rst_n=0 SHALL asynchronously force S_IDLE, wcnt=0, o_mem_cs=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rvalid=0 pipeline cleared; o_rgnt and o_wready are 0 while rst_n=0.
REQ-014 Reset mid-access SHALL discard in-flight reads: no o_rvalid after deassertion for pre-reset accepts.

Configuration
REQ-015 Macro FMA_STARVE_GUARD_EN defined: when wcnt==STARVE_LIMIT and both request, the write SHALL win (o_wready=1, o_rgnt=0) for exactly one cycle, then read priority resumes.
REQ-016 Macro not defined: strict read priority; wcnt SHALL still count but never alter arbitration.

Verification
REQ-017 Scenarios:
- Reset: rst_n=0 mid-burst -> all outputs 0 immediately; no stale o_rvalid after release.
- Read only: i_ren=1 addr 0..3 for 4 cycles -> o_mem_cs=1, we=0 cycles N+1..N+4; o_rvalid cycles N+2..N+5 with preloaded data.
- Write only: i_wvalid=1 addr 5, data 0xA5 -> o_wready=1 same cycle; cs=1, we=1, addr 5, wdata 0xA5 next cycle.
- Contention, macro off: both requesting 20 cycles -> 20 reads, o_wready=0 throughout, wcnt saturates at 8.
- Contention, FMA_STARVE_GUARD_EN: both requesting -> 8 reads, 1 write on 9th cycle, reads resume; o_rgnt/o_wready never both 1.
- Write then read same address 7, data 0x3C -> o_rdata=0x3C with o_rvalid.

Source files
------------

// File: rtl/frame_mem_arbiter.sv
// Read/write arbiter sharing one single-port frame SRAM between a display reader and an input writer.
// Optional build macro FMA_STARVE_GUARD_EN: a write starved for STARVE_LIMIT cycles wins one cycle.
module frame_mem_arbiter #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_DEPTH   = 512*512/4,
  parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rgnt,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_wvalid,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_wready,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [1:0]            o_dbg_state,
  output logic [7:0]            o_dbg_wcnt
);

  // Handshake: a request (i_ren / i_wvalid) is accepted in the cycle its grant
  // (o_rgnt / o_wready) is 1; until then the requester holds request, address and
  // data stable, and nothing of an ungranted request is captured here.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  force_wr;
  logic                  rgnt;
  logic                  wgnt;

  always_comb begin
    force_wr = 1'b0;
`ifdef FMA_STARVE_GUARD_EN
    force_wr = (wcnt_q == STARVE_LIM8);
`endif
    // Grants are held low while reset is asserted so nothing is accepted then.
    rgnt = rst_n & i_ren & ~(force_wr & i_wvalid);
    wgnt = rst_n & i_wvalid & (~i_ren | force_wr);
  end

  always_comb begin
    state_d  = S_IDLE;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = (state_q == S_RD);
    wcnt_d   = wcnt_q;
    if (rgnt) begin
      state_d = S_RD;
      addr_d  = i_raddr;
    end else if (wgnt) begin
      state_d = S_WR;
      addr_d  = i_waddr;
      wdata_d = i_wdata;
    end
    if (!i_wvalid || wgnt) begin
      wcnt_d = 8'd0;
    end else if (wcnt_q < STARVE_LIM8) begin
      wcnt_d = wcnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // The SRAM returns data one cycle after a read is issued, so o_rdata is a wire.
  assign o_rgnt      = rgnt;
  assign o_wready    = wgnt;
  assign o_mem_cs    = (state_q != S_IDLE);
  assign o_mem_we    = (state_q == S_WR);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = i_mem_rdata;
  assign o_dbg_state = state_q;
  assign o_dbg_wcnt  = wcnt_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a behavioural single-port SRAM.
// Contention expectations follow FMA_STARVE_GUARD_EN when it is defined.
module tb_frame_mem_arbiter;

  localparam int DW = 96;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_ren = 1'b0;
  logic [AW-1:0] i_raddr = '0;
  logic          o_rgnt;
  logic          o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          i_wvalid = 1'b0;
  logic [AW-1:0] i_waddr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          o_wready;
  logic          o_mem_cs;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata = '0;
  logic [1:0]    o_dbg_state;
  logic [7:0]    o_dbg_wcnt;

  int errors = 0;
  int checks = 0;

  frame_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)
  ) dut (
    .i_clk(i_clk), .rst_n(rst_n),
    .i_ren(i_ren), .i_raddr(i_raddr), .o_rgnt(o_rgnt),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .i_wvalid(i_wvalid), .i_waddr(i_waddr), .i_wdata(i_wdata), .o_wready(o_wready),
    .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state), .o_dbg_wcnt(o_dbg_wcnt)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] pre_word(int i);
    pre_word = {32'hC0DE_0000 | 32'(i), 32'h1234_5678, 32'h0BAD_F000 | 32'(i)};
  endfunction

  // Behavioural SRAM: preloaded while reset is low, one-cycle read latency.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge i_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_word(i);
    end else if (o_mem_cs) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else i_mem_rdata <= mem[o_mem_addr];
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_ren = 1'b1; i_wvalid = 1'b1; i_waddr = 6'd3; i_wdata = 96'hFF;
    #3;
    checks++; if (o_rgnt !== 1'b0) begin errors++; $display("FAIL rst_rgnt got %0h exp 0", o_rgnt); end
    checks++; if (o_wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %0h exp 0", o_wready); end
    tick;
    checks++; if (o_mem_cs !== 1'b0 || o_mem_we !== 1'b0) begin errors++; $display("FAIL rst_cs_we got %0h/%0h exp 0/0", o_mem_cs, o_mem_we); end
    checks++; if (o_mem_addr !== 6'd0 || o_mem_wdata !== 96'd0) begin errors++; $display("FAIL rst_addr_wdata got %0h/%0h exp 0/0", o_mem_addr, o_mem_wdata); end
    checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0h exp 0", o_rvalid); end
    checks++; if (o_dbg_state !== 2'd0 || o_dbg_wcnt !== 8'd0) begin errors++; $display("FAIL rst_state_wcnt got %0h/%0h exp 0/0", o_dbg_state, o_dbg_wcnt); end
    i_ren = 1'b0; i_wvalid = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_read_only;
    for (int t = 0; t < 7; t++) begin
      tick;
      i_ren = (t < 4); i_raddr = 6'(t);
      #1;
      checks++; if (o_rgnt !== (t < 4) || o_wready !== 1'b0) begin errors++; $display("FAIL rd_grant t=%0d got %0h/%0h exp %0h/0", t, o_rgnt, o_wready, (t < 4)); end
      checks++; if (o_mem_cs !== (t >= 1 && t <= 4) || o_mem_we !== 1'b0) begin errors++; $display("FAIL rd_cs_we t=%0d got %0h/%0h", t, o_mem_cs, o_mem_we); end
      if (t >= 1 && t <= 4) begin
        checks++; if (o_mem_addr !== 6'(t - 1)) begin errors++; $display("FAIL rd_addr t=%0d got %0h exp %0h", t, o_mem_addr, t - 1); end
      end
      checks++; if (o_rvalid !== (t >= 2 && t <= 5)) begin errors++; $display("FAIL rd_rvalid t=%0d got %0h exp %0h", t, o_rvalid, (t >= 2 && t <= 5)); end
      if (t >= 2 && t <= 5) begin
        checks++; if (o_rdata !== pre_word(t - 2)) begin errors++; $display("FAIL rd_data t=%0d got %0h exp %0h", t, o_rdata, pre_word(t - 2)); end
      end
    end
    i_ren = 1'b0;
  endtask

  task automatic test_write_only;
    tick;
    i_wvalid = 1'b1; i_waddr = 6'd5; i_wdata = 96'hA5;
    #1;
    checks++; if (o_wready !== 1'b1 || o_rgnt !== 1'b0) begin errors++; $display("FAIL wr_grant got %0h/%0h exp 1/0", o_wready, o_rgnt); end
    tick;
    i_wvalid = 1'b0; i_waddr = 6'd0; i_wdata = '0;
    #1;
    checks++; if (o_mem_cs !== 1'b1 || o_mem_we !== 1'b1) begin errors++; $display("FAIL wr_cs_we got %0h/%0h exp 1/1", o_mem_cs, o_mem_we); end
    checks++; if (o_mem_addr !== 6'd5 || o_mem_wdata !== 96'hA5) begin errors++; $display("FAIL wr_addr_data got %0h/%0h exp 5/a5", o_mem_addr, o_mem_wdata); end
    checks++; if (o_dbg_state !== 2'd2) begin errors++; $display("FAIL wr_state got %0h exp 2", o_dbg_state); end
    checks++; if (o_wready !== 1'b0) begin errors++; $display("FAIL wr_drop got %0h exp 0", o_wready); end
    tick;
    checks++; if (o_mem_cs !== 1'b0 || o_mem_we !== 1'b0) begin errors++; $display("FAIL wr_idle got %0h/%0h exp 0/0", o_mem_cs, o_mem_we); end
  endtask

  task automatic test_contention;
    logic exp_w;
    logic [7:0] exp_cnt;
    int nrd;
    nrd = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      i_ren = 1'b1; i_raddr = 6'(c % 4);
      i_wvalid = 1'b1; i_waddr = 6'd9; i_wdata = 96'h99;
      #1;
`ifdef FMA_STARVE_GUARD_EN
      exp_w = (c == 8 || c == 17);
      exp_cnt = (c <= 8) ? 8'(c) : ((c <= 17) ? 8'(c - 9) : 8'(c - 18));
`else
      exp_w = 1'b0;
      exp_cnt = (c < 8) ? 8'(c) : 8'd8;
`endif
      if (o_rgnt === 1'b1) nrd++;
      checks++; if (o_rgnt !== ~exp_w || o_wready !== exp_w) begin errors++; $display("FAIL cont_grant c=%0d got %0h/%0h exp %0h/%0h", c, o_rgnt, o_wready, ~exp_w, exp_w); end
      checks++; if (o_rgnt === 1'b1 && o_wready === 1'b1) begin errors++; $display("FAIL cont_both c=%0d got 1/1 exp not both", c); end
      checks++; if (o_dbg_wcnt !== exp_cnt) begin errors++; $display("FAIL cont_wcnt c=%0d got %0d exp %0d", c, o_dbg_wcnt, exp_cnt); end
    end
`ifdef FMA_STARVE_GUARD_EN
    checks++; if (nrd != 18) begin errors++; $display("FAIL cont_reads got %0d exp 18", nrd); end
`else
    checks++; if (nrd != 20) begin errors++; $display("FAIL cont_reads got %0d exp 20", nrd); end
`endif
    tick;
    i_ren = 1'b0; i_wvalid = 1'b0;
    tick;
    checks++; if (o_dbg_wcnt !== 8'd0) begin errors++; $display("FAIL cont_wcnt_clear got %0d exp 0", o_dbg_wcnt); end
    tick;
    tick;
  endtask

  task automatic test_write_then_read;
    tick;
    i_wvalid = 1'b1; i_waddr = 6'd7; i_wdata = 96'h3C;
    #1;
    checks++; if (o_wready !== 1'b1) begin errors++; $display("FAIL wtr_wready got %0h exp 1", o_wready); end
    tick;
    i_wvalid = 1'b0; i_ren = 1'b1; i_raddr = 6'd7;
    #1;
    checks++; if (o_rgnt !== 1'b1) begin errors++; $display("FAIL wtr_rgnt got %0h exp 1", o_rgnt); end
    tick;
    i_ren = 1'b0;
    #1;
    checks++; if (o_mem_cs !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 6'd7 || o_dbg_state !== 2'd1) begin errors++; $display("FAIL wtr_issue got cs=%0h we=%0h addr=%0h st=%0h exp 1/0/7/1", o_mem_cs, o_mem_we, o_mem_addr, o_dbg_state); end
    tick;
    checks++; if (o_rvalid !== 1'b1 || o_rdata !== 96'h3C) begin errors++; $display("FAIL wtr_data got v=%0h d=%0h exp 1/3c", o_rvalid, o_rdata); end
    tick;
    checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL wtr_rvalid_end got %0h exp 0", o_rvalid); end
  endtask

  task automatic test_reset_mid_burst;
    for (int k = 0; k < 3; k++) begin
      tick;
      i_ren = 1'b1; i_raddr = 6'(k + 1);
      #1;
    end
    checks++; if (o_rvalid !== 1'b1) begin errors++; $display("FAIL mid_burst_active got %0h exp 1", o_rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_rvalid !== 1'b0 || o_mem_cs !== 1'b0 || o_mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got v=%0h cs=%0h we=%0h exp 0/0/0", o_rvalid, o_mem_cs, o_mem_we); end
    checks++; if (o_rgnt !== 1'b0 || o_wready !== 1'b0) begin errors++; $display("FAIL mid_rst_grants got %0h/%0h exp 0/0", o_rgnt, o_wready); end
    checks++; if (o_mem_addr !== 6'd0 || o_dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_addr_state got %0h/%0h exp 0/0", o_mem_addr, o_dbg_state); end
    tick;
    i_ren = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (o_rvalid !== 1'b0 || o_mem_cs !== 1'b0) begin errors++; $display("FAIL mid_stale k=%0d got v=%0h cs=%0h exp 0/0", k, o_rvalid, o_mem_cs); end
    end
  endtask

  initial begin
    test_reset;
    test_read_only;
    test_write_only;
    test_contention;
    test_write_then_read;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
